// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with true-LRU replacement,
// multiple combinational read ports, single-entry invalidate and flush sweep.
module btb_assoc #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int TAG_W = 8,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  input  logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_hit,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     inv_en,
  input  logic [IDX_W-1:0]         inv_idx,
  input  logic [TAG_W-1:0]         inv_tag,
  input  logic                     flush_req,
  output logic                     flush_busy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t state, state_n;
  logic [IDX_W-1:0] cnt;

  logic             valid [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tags  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] data [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] age   [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] rd_set0;
  logic [WAY_W-1:0] hit_way0;
  logic [WAY_W-1:0] m_way, i_way, v_way, wsel, inv_way;
  logic             m_fnd, i_fnd, inv_hit;
  logic             wr_acc, inv_acc, p0_touch;

  assign rd_set0 = rd_idx[IDX_W-1:0];

  // Reads are blocked while the sweep runs so a half-flushed table never hits.
  always_comb begin
    rd_hit = '0;
    rd_data = '0;
    hit_way0 = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (rd_en[p] && !flush_busy &&
            valid[rd_idx[p*IDX_W +: IDX_W]][w] &&
            tags[rd_idx[p*IDX_W +: IDX_W]][w] == rd_tag[p*TAG_W +: TAG_W]) begin
          rd_hit[p] = 1'b1;
          rd_data[p*DATA_W +: DATA_W] = data[rd_idx[p*IDX_W +: IDX_W]][w];
          if (p == 0) hit_way0 = WAY_W'(w);
        end
      end
    end
  end

  always_comb begin
    m_fnd = 1'b0;
    i_fnd = 1'b0;
    m_way = '0;
    i_way = '0;
    v_way = '0;
    inv_hit = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[wr_idx][w] && tags[wr_idx][w] == wr_tag) begin
        m_fnd = 1'b1;
        m_way = WAY_W'(w);
      end
      if (!valid[wr_idx][w]) begin
        i_fnd = 1'b1;
        i_way = WAY_W'(w);
      end
      if (age[wr_idx][w] == WAY_W'(NUM_WAYS - 1)) v_way = WAY_W'(w);
      if (valid[inv_idx][w] && tags[inv_idx][w] == inv_tag) begin
        inv_hit = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    wsel = m_fnd ? m_way : (i_fnd ? i_way : v_way);
  end

  assign wr_acc   = wr_en && wr_ready;
  assign inv_acc  = inv_en && !flush_busy && inv_hit;
  assign p0_touch = rd_hit[0] && !(wr_acc && wr_idx == rd_set0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid[s][w] <= 1'b0;
          tags[s][w]  <= '0;
          data[s][w]  <= '0;
          age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (flush_busy) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid[cnt][w] <= 1'b0;
          age[cnt][w]   <= WAY_W'(w);
        end
      end
      if (p0_touch) begin
        for (int w = 0; w < NUM_WAYS; w++)
          if (age[rd_set0][w] < age[rd_set0][hit_way0])
            age[rd_set0][w] <= age[rd_set0][w] + WAY_W'(1);
        age[rd_set0][hit_way0] <= '0;
      end
      if (inv_acc) valid[inv_idx][inv_way] <= 1'b0;
      // Later assignment lets a same-entry write override the invalidate.
      if (wr_acc) begin
        valid[wr_idx][wsel] <= 1'b1;
        tags[wr_idx][wsel]  <= wr_tag;
        data[wr_idx][wsel]  <= wr_data;
        for (int w = 0; w < NUM_WAYS; w++)
          if (age[wr_idx][w] < age[wr_idx][wsel])
            age[wr_idx][w] <= age[wr_idx][w] + WAY_W'(1);
        age[wr_idx][wsel] <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == SWEEP) cnt <= cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (flush_req) state_n = SWEEP;
      SWEEP: if (cnt == IDX_W'(NUM_SETS - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    flush_busy = (state == SWEEP);
    wr_ready   = (state != SWEEP);
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: stimulus queues expected read results,
// a negedge monitor pops and compares whenever a lookup is presented.
module tb_btb_assoc;
  localparam int NS = 4, NW = 2, TW = 8, DW = 32, NR = 2, IW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR*IW-1:0] rd_idx;
  logic [NR*TW-1:0] rd_tag;
  logic [NR-1:0]    rd_en;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_hit;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [TW-1:0]    wr_tag;
  logic [DW-1:0]    wr_data;
  logic             wr_ready;
  logic             inv_en;
  logic [IW-1:0]    inv_idx;
  logic [TW-1:0]    inv_tag;
  logic             flush_req;
  logic             flush_busy;

  btb_assoc #(
    .NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW), .DATA_W(DW), .NUM_RD(NR)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_en(rd_en),
    .rd_data(rd_data), .rd_hit(rd_hit),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .inv_en(inv_en), .inv_idx(inv_idx), .inv_tag(inv_tag),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (rd_en != '0) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL queue: got empty want entry");
      end else begin
        e = q.pop_front();
        chk("hit", 32'(rd_hit), 32'(e.hit));
        chk("data0", rd_data[31:0], e.d0);
        chk("data1", rd_data[63:32], e.d1);
        chk("busy", 32'(flush_busy), 32'(e.busy));
        chk("ready", 32'(wr_ready), 32'(e.ready));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    rd_en = '0;
    wr_en = 1'b0;
    inv_en = 1'b0;
    flush_req = 1'b0;
  endtask

  // h is {port1, port0}
  task automatic look(input logic [1:0] i0, input logic [7:0] t0,
                      input logic [1:0] i1, input logic [7:0] t1,
                      input logic [1:0] h, input logic [31:0] d0,
                      input logic [31:0] d1, input logic busy);
    rd_en = 2'b11;
    rd_idx = {i1, i0};
    rd_tag = {t1, t0};
    q.push_back('{hit: h, d0: d0, d1: d1, busy: busy, ready: !busy});
  endtask

  task automatic wr(input logic [1:0] i, input logic [7:0] t,
                    input logic [31:0] d);
    wr_en = 1'b1;
    wr_idx = i;
    wr_tag = t;
    wr_data = d;
  endtask

  task automatic inv(input logic [1:0] i, input logic [7:0] t);
    inv_en = 1'b1;
    inv_idx = i;
    inv_tag = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rd_en = '0; rd_idx = '0; rd_tag = '0;
    wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_data = '0;
    inv_en = 1'b0; inv_idx = '0; inv_tag = '0;
    flush_req = 1'b0;
    step();
    look(0, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0); step();
    reset = 1'b0;
    look(0, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0); step();

    // idx1 fill and read-during-write
    wr(1, 8'h11, 32'hAAAA);
    look(1, 8'h11, 1, 8'h11, 2'b00, 0, 0, 0); step();
    wr(1, 8'h22, 32'hBBBB);
    look(1, 8'h11, 1, 8'h22, 2'b01, 32'hAAAA, 0, 0); step();
    look(1, 8'h11, 1, 8'h22, 2'b11, 32'hAAAA, 32'hBBBB, 0); step();
    wr(1, 8'h33, 32'hCCCC); step();
    look(1, 8'h11, 1, 8'h33, 2'b11, 32'hAAAA, 32'hCCCC, 0); step();
    look(1, 8'h22, 1, 8'h22, 2'b00, 0, 0, 0); step();

    // idx3: port-0 hit and write in the same set, same cycle
    wr(3, 8'h11, 32'h1111); step();
    wr(3, 8'h22, 32'h2222); step();
    wr(3, 8'h33, 32'h3333);
    look(3, 8'h11, 3, 8'h22, 2'b11, 32'h1111, 32'h2222, 0); step();
    look(3, 8'h33, 3, 8'h22, 2'b11, 32'h3333, 32'h2222, 0); step();
    look(3, 8'h11, 3, 8'h11, 2'b00, 0, 0, 0); step();
    wr(3, 8'h44, 32'h4444); step();
    look(3, 8'h22, 3, 8'h44, 2'b10, 0, 32'h4444, 0); step();

    // idx2: same-tag update, invalidate, invalidate vs write
    wr(2, 8'h11, 32'h1); step();
    wr(2, 8'h11, 32'h2); step();
    look(2, 8'h11, 2, 8'h00, 2'b01, 32'h2, 0, 0); step();
    wr(2, 8'h55, 32'h5); step();
    look(2, 8'h11, 2, 8'h55, 2'b11, 32'h2, 32'h5, 0); step();
    inv(2, 8'h55);
    look(2, 8'h55, 2, 8'h11, 2'b11, 32'h5, 32'h2, 0); step();
    look(2, 8'h55, 2, 8'h11, 2'b10, 0, 32'h2, 0); step();
    inv(2, 8'h11); wr(2, 8'h11, 32'h7); step();
    look(2, 8'h11, 2, 8'h55, 2'b01, 32'h7, 0, 0); step();

    // flush sweep
    wr(0, 8'h66, 32'h6); step();
    flush_req = 1'b1;
    look(0, 8'h66, 1, 8'h11, 2'b11, 32'h6, 32'hAAAA, 0); step();
    for (int i = 0; i < NS; i++) begin
      if (i == 1) wr(1, 8'h77, 32'h77);
      if (i == 2) flush_req = 1'b1;
      look(0, 8'h66, 1, 8'h11, 2'b00, 0, 0, 1); step();
    end
    look(0, 8'h66, 1, 8'h11, 2'b00, 0, 0, 0); step();
    look(2, 8'h11, 3, 8'h33, 2'b00, 0, 0, 0); step();
    look(1, 8'h77, 3, 8'h44, 2'b00, 0, 0, 0); step();
    wr(1, 8'h88, 32'h88); step();
    look(1, 8'h88, 1, 8'h88, 2'b11, 32'h88, 32'h88, 0); step();

    // reset in the middle of a sweep
    flush_req = 1'b1; step();
    look(1, 8'h88, 1, 8'h88, 2'b00, 0, 0, 1); step();
    reset = 1'b1;
    look(1, 8'h88, 1, 8'h88, 2'b00, 0, 0, 0); step();
    reset = 1'b0;
    look(1, 8'h88, 0, 8'h00, 2'b00, 0, 0, 0); step();

    step();
    chk("drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer; successor of the direct-mapped BTB.
- Adds per-entry valid bits, N-way sets with true-LRU replacement, and multiple combinational read ports.
- Adds a single-entry invalidate and a sequential whole-table flush engine.
- Sits between fetch (read port 0, which trains LRU) and the branch-resolve/retire write path.

Parameters:
- NUM_SETS, 16, number of sets; power of 2, >=2; IDX_W = $clog2(NUM_SETS).
- NUM_WAYS, 2, ways per set; power of 2, 1..8; WAY_W = max(1,$clog2(NUM_WAYS)).
- TAG_W, 8, tag width.
- DATA_W, 32, target width.
- NUM_RD, 2, number of read ports, >=1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_idx  in  NUM_RD*IDX_W  per-port set index.
- rd_tag  in  NUM_RD*TAG_W  per-port tag.
- rd_en  in  NUM_RD  per-port lookup enable; only port 0 updates LRU.
- rd_data  out  NUM_RD*DATA_W  per-port target.
- rd_hit  out  NUM_RD  per-port hit.
- wr_en  in  1  write/allocate request.
- wr_idx  in  IDX_W  write set.
- wr_tag  in  TAG_W  write tag.
- wr_data  in  DATA_W  write target.
- wr_ready  out  1  write accepted this cycle.
- inv_en  in  1  invalidate the matching entry.
- inv_idx  in  IDX_W  invalidate set.
- inv_tag  in  TAG_W  invalidate tag.
- flush_req  in  1  pulse: start whole-table flush.
- flush_busy  out  1  flush sweep in progress.

Behaviour:
- Reset (async):
  - All valid=0, tags=0, data=0.
  - Age of way w in every set = w.
  - FSM=IDLE, sweep counter=0.
  - Outputs: rd_hit=0, rd_data=0, flush_busy=0, wr_ready=1.
- Read (combinational, 0 latency):
  - rd_hit[p] = rd_en[p] & !flush_busy & (some way in set rd_idx[p] is valid with tag==rd_tag[p]).
  - rd_data[p] = data of the hit way, else 0.
  - At most one way matches per set: this is an invariant, guaranteed by the write rule.
- Read-during-write to the same entry: the read returns the pre-write contents; the new value is visible the next cycle.
- Write (accepted when wr_en & wr_ready; wr_ready = !flush_busy; writes while busy are dropped):
  - Way selection: tag-match way if one exists; else the lowest-index invalid way; else the victim way (age == NUM_WAYS-1).
  - Selected way gets tag, data and valid=1, and is touched.
- LRU touch of way w in a set:
  - Every way with age < age[w] increments; age[w] becomes 0.
  - Ages in every set remain a permutation of 0..NUM_WAYS-1.
  - A port-0 read hit (rd_en[0] & rd_hit[0]) touches the hit way.
  - If a write and a port-0 hit target the same set in one cycle, only the write touch is applied.
  - If they target different sets, both touches are applied.
  - NUM_WAYS=1: ages are constant 0.
- Invalidate: inv_en with a matching valid entry clears valid the next edge; ages are unchanged; no match means no effect.
  - If invalidate and an accepted write hit the same entry in one cycle, the write wins (entry stays valid with the new data).
- Flush FSM (IDLE, SWEEP):
  - IDLE: flush_req moves to SWEEP with counter=0; flush_busy=1 from the next cycle.
  - SWEEP: each cycle clears valid of all ways in set[counter] and resets its ages to way index, then counter++.
  - After set NUM_SETS-1 is cleared, return to IDLE; the counter wraps to 0.
  - Busy lasts exactly NUM_SETS cycles.
  - flush_req during SWEEP is ignored (no restart).
  - inv_en during SWEEP is ignored.
  - Reset during SWEEP aborts the sweep and applies the full reset values immediately.
- Width rules: indices are used unsigned and never out of range by construction; no arithmetic overflow, since ages are bounded by NUM_WAYS-1.

Test Plan:
- (All scenarios use NUM_SETS=4, NUM_WAYS=2, TAG_W=8, DATA_W=32, NUM_RD=2.)
- Reset, then read idx0 tag0 on both ports -> rd_hit=00, rd_data=0 (tags reset to 0 but invalid, so no false hit).
- Write idx1/tag 0x11/0xAAAA, then idx1/tag 0x22/0xBBBB -> port0 idx1 tag 0x11 hits with 0xAAAA; port1 idx1 tag 0x22 hits with 0xBBBB the same cycle; a same-cycle read of the first write before its edge misses.
- Fill idx1 with tags 0x11 and 0x22, port-0 read hit tag 0x11, then write tag 0x33 -> 0x22 evicted; 0x11 and 0x33 hit, 0x22 misses.
- Repeat the previous scenario but drive the port-0 hit on 0x11 in the same cycle as the write of 0x33 -> write touch wins; victim stays 0x22 only if it was older, per the age rule; check ages = {way(0x33):0, other:1}.
- Write tag 0x11 data 0x1 to idx2, then write tag 0x11 data 0x2 to idx2 -> same way updated, the other way stays invalid, read returns 0x2.
- Fill all sets, pulse flush_req, assert wr_en at sweep cycle 1 -> flush_busy high exactly 4 cycles, wr_ready=0 and the write dropped, all reads miss afterward; second flush_req mid-sweep does not extend busy; async reset mid-sweep immediately gives flush_busy=0.
